byte_frame_parser: RTL and testbench

- Downstream stage of the 2-bit-to-byte consolidation block. It consumes the consolidated byte stream (din/din_en, one byte per strobe, gaps allowed).
- Hunts for a sync byte, reads a length byte, forwards the payload bytes and checks a trailing XOR checksum.
- Emits the payload as a byte stream plus a per-frame pass/fail pulse for the next processing stage.

---
 rtl/byte_frame_pkg.sv | 15 +
 rtl/frame_stat_cnt.sv | 19 +
 rtl/byte_frame_parser.sv | 124 ++++++++++++
 tb/tb_byte_frame_parser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_frame_pkg.sv
// Shared types and constants for the byte frame parser slice.
// Optional build macro used by the parser: BYTE_FRAME_STAT_EN.
package byte_frame_pkg;

    localparam int         LEN_W    = 8;
    localparam logic [7:0] SYNC_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PLD,
        CHK
    } state_t;

endpackage

// File: rtl/frame_stat_cnt.sv
// Saturating 16-bit event counter for frame statistics.
// Instantiated by byte_frame_parser only under BYTE_FRAME_STAT_EN.
module frame_stat_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    output logic [15:0] cnt
);

    // Count one event per inc cycle, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/byte_frame_parser.sv
// Sync/length/payload/XOR-checksum frame parser on a byte stream.
// Define BYTE_FRAME_STAT_EN to add ok_cnt/err_cnt frame counters.
module byte_frame_parser
    import byte_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
    parameter int         MAX_LEN   = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] din,
    input  logic       din_en,
    output logic [7:0] pld_data,
    output logic       pld_en,
    output logic       pld_last,
    output logic       frame_ok,
    output logic       frame_err
`ifdef BYTE_FRAME_STAT_EN
    ,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [7:0]       chk, chk_n;
    logic [7:0]       data_n;
    logic             en_n, last_n, ok_n, err_n;

    // State, frame context and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            chk       <= '0;
            pld_data  <= '0;
            pld_en    <= 1'b0;
            pld_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            chk       <= chk_n;
            pld_data  <= data_n;
            pld_en    <= en_n;
            pld_last  <= last_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
        end
    end

    // Next state and output values; only accepted bytes move the FSM.
    always_comb begin
        state_n = state;
        len_n   = len;
        cnt_n   = cnt;
        chk_n   = chk;
        data_n  = pld_data;
        en_n    = 1'b0;
        last_n  = 1'b0;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        if (din_en) begin
            unique case (state)
                IDLE: begin
                    if (din == SYNC_BYTE) state_n = LEN;
                end
                LEN: begin
                    len_n = din;
                    chk_n = din;
                    cnt_n = '0;
                    if (din == '0) begin
                        state_n = CHK;
                    end else if (din > MAX_L) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = PLD;
                    end
                end
                PLD: begin
                    chk_n  = chk ^ din;
                    cnt_n  = cnt + 8'd1;
                    data_n = din;
                    en_n   = 1'b1;
                    if (cnt == len - 8'd1) begin
                        last_n  = 1'b1;
                        state_n = CHK;
                    end
                end
                CHK: begin
                    ok_n    = (din == chk);
                    err_n   = (din != chk);
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef BYTE_FRAME_STAT_EN
    frame_stat_cnt u_ok_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (frame_ok),
        .cnt  (ok_cnt)
    );

    frame_stat_cnt u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (frame_err),
        .cnt  (err_cnt)
    );
`endif

endmodule

// File: tb/tb_byte_frame_parser.sv
// Randomized bench for byte_frame_parser against a stream-level model.
// Build with BYTE_FRAME_STAT_EN defined to also check the counters.
module tb_byte_frame_parser;

    localparam int         MAXL = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic       en;
        logic       last;
        logic [7:0] data;
        logic       ok;
        logic       err;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_en = 1'b0;
    logic [7:0] pld_data;
    logic       pld_en;
    logic       pld_last;
    logic       frame_ok;
    logic       frame_err;
`ifdef BYTE_FRAME_STAT_EN
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
`endif

    logic [7:0] strm[$];
    ev_t        evq[$];
    logic [7:0] hold = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_ok = 0;
    int         exp_err = 0;

    always #5 clk = ~clk;

    byte_frame_parser #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXL)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_en    (din_en),
        .pld_data  (pld_data),
        .pld_en    (pld_en),
        .pld_last  (pld_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
`ifdef BYTE_FRAME_STAT_EN
        ,
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic en, input logic last,
                               input logic [7:0] data,
                               input logic ok, input logic err);
        ev_t e;
        e.en   = en;
        e.last = last;
        e.data = data;
        e.ok   = ok;
        e.err  = err;
        return e;
    endfunction

    // Scan the whole byte stream frame by frame and record, for each
    // byte, what the outputs must show one cycle after it is accepted.
    function automatic void build_model();
        int         i = 0;
        int         n = strm.size();
        int         l;
        logic [7:0] c;
        evq.delete();
        for (int k = 0; k < n; k++) evq.push_back('0);
        while (i < n) begin
            if (strm[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            l = int'(strm[i]);
            c = strm[i];
            if (l > MAXL) begin
                evq[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                i++;
                continue;
            end
            i++;
            for (int p = 0; p < l && i < n; p++) begin
                evq[i] = mk(1'b1, p == l - 1, strm[i], 1'b0, 1'b0);
                c = c ^ strm[i];
                i++;
            end
            if (i >= n) break;
            evq[i] = mk(1'b0, 1'b0, 8'h00, strm[i] == c, strm[i] != c);
            i++;
        end
    endfunction

    task automatic check_out(input ev_t e);
        if (e.en) hold = e.data;
        check_eq("pld_en", 16'(pld_en), 16'(e.en));
        check_eq("pld_data", 16'(pld_data), 16'(hold));
        check_eq("pld_last", 16'(pld_last), 16'(e.last));
        check_eq("frame_ok", 16'(frame_ok), 16'(e.ok));
        check_eq("frame_err", 16'(frame_err), 16'(e.err));
        if (e.ok) exp_ok++;
        if (e.err) exp_err++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            din_en = 1'b0;
            din    = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_out('0);
        end
    endtask

    task automatic do_reset(input int n);
        rstn   = 1'b0;
        din_en = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        hold    = 8'h00;
        exp_ok  = 0;
        exp_err = 0;
        check_out('0);
    endtask

    task automatic run_stream(input int gap_max);
        int g;
        build_model();
        for (int k = 0; k < strm.size(); k++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            idle(g);
            din_en = 1'b1;
            din    = strm[k];
            @(posedge clk);
            @(negedge clk);
            check_out(evq[k]);
        end
        din_en = 1'b0;
        strm.delete();
    endtask

    task automatic add_frame(input int len, input bit bad);
        logic [7:0] c;
        logic [7:0] b;
        strm.push_back(SYNC);
        strm.push_back(8'(len));
        if (len > MAXL) return;
        c = 8'(len);
        for (int p = 0; p < len; p++) begin
            b = 8'($urandom);
            strm.push_back(b);
            c = c ^ b;
        end
        strm.push_back(bad ? ~c : c);
    endtask

    task automatic add_junk(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            strm.push_back(b);
        end
    endtask

    initial begin
        do_reset(2);

        strm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_stream(0);
        strm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};
        run_stream(0);
        strm = {8'hA5, 8'h00, 8'h00};
        run_stream(0);
        strm = {8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        run_stream(0);

        strm = {8'h00, 8'hFF, 8'h5A};
        add_frame(int'($urandom_range(MAXL, 1)), 1'b0);
        run_stream(3);

        strm = {8'hA5, 8'h02, 8'h10};
        run_stream(0);
        do_reset(1);
        idle(2);
        add_frame(4, 1'b0);
        run_stream(0);

        add_frame(MAXL, 1'b0);
        add_frame(MAXL + 1, 1'b0);
        add_frame(255, 1'b0);
        add_frame(1, 1'b1);
        run_stream(1);

        repeat (30) begin
            add_junk(int'($urandom_range(3, 0)));
            add_frame(int'($urandom_range(20, 0)), $urandom_range(3, 0) == 0);
            run_stream(2);
        end
        idle(2);

`ifdef BYTE_FRAME_STAT_EN
        do_reset(1);
        add_frame(3, 1'b0);
        add_frame(0, 1'b0);
        add_frame(5, 1'b1);
        run_stream(1);
        idle(2);
        check_eq("ok_cnt", ok_cnt, 16'(exp_ok));
        check_eq("err_cnt", err_cnt, 16'(exp_err));
        check_eq("ok_cnt_two", ok_cnt, 16'd2);
        check_eq("err_cnt_one", err_cnt, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
